uart_cmd_tx: RTL and testbench
==============================

// Module: uart_cmd_tx
// PURPOSE
//  Host-side command transmitter for the temperature-sensor UART link. It takes
//  one command per handshake (set high threshold, set low threshold, enable or
//  disable streaming) and serializes it as a 2-byte frame on tx. The frame goes
//  to the sensor's rx pin, where the command controller loads temp_high/temp_low
//  or gates data sending.
//  Used on the companion/test FPGA and as the bench driver for the sensor top.
// PARAMETERS
//  CLK_FREQ  10000  input clock frequency, Hz
//  BAUD      1000   UART bit rate; bit period BIT_CYC = CLK_FREQ/BAUD (>=2, integer)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active high
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  high when a command can be accepted
//  cmd_op     in   2  0=SET_HIGH, 1=SET_LOW, 2=SEND_CTRL, 3=reserved
//  cmd_data   in   8  threshold value, or bit0 = streaming enable for SEND_CTRL
//  tx         out  1  UART serial output, 8N1, LSB first, idle high
//  busy       out  1  frame in progress
//  done       out  1  one-cycle pulse at end of the data byte's stop bit
//  err        out  1  one-cycle pulse when a reserved op is rejected
// BEHAVIOUR
//  Reset values: tx=1, cmd_ready=1, busy=0, done=0, err=0; FSM=IDLE; counters=0.
//  Opcode bytes: SET_HIGH=8'hA1, SET_LOW=8'hA2, SEND_CTRL=8'hA3.
//  SEND_CTRL data byte = {7'b0, cmd_data[0]}.
//  Handshake:
//   - Accept on cmd_valid & cmd_ready (rising clk).
//   - cmd_op and cmd_data are latched on accept and ignored afterwards.
//   - cmd_ready = (state==IDLE); it drops the cycle after accept.
//  Reserved op (3):
//   - Accepted, err pulses the next cycle, nothing is transmitted.
//   - FSM stays in IDLE; cmd_ready stays high.
//  FSM states and transitions:
//   - IDLE -> OP_BYTE on accept.
//   - OP_BYTE -> DATA_BYTE after the op byte's stop bit.
//   - DATA_BYTE -> DONE after the data byte's stop bit.
//   - DONE -> IDLE after 1 cycle; done=1 in DONE.
//  Byte timing:
//   - Each byte is start(0), d0..d7, stop(1): 10 bit periods of BIT_CYC cycles.
//   - The start bit of the op byte drives tx the cycle after accept.
//   - The data-byte start bit follows the op-byte stop bit with no idle gap.
//   - Frame length = 20*BIT_CYC cycles from first start-bit cycle to DONE.
//   - busy=1 throughout OP_BYTE and DATA_BYTE.
//  tx is registered (glitch-free). Bit counter 0..9; baud counter 0..BIT_CYC-1,
//  sized $clog2(BIT_CYC).
//  cmd_valid held high through DONE: the next command is accepted in the IDLE
//  cycle after DONE, giving back-to-back frames with one idle-high cycle between.
//  Reset asserted mid-frame: tx forced high immediately (async), frame discarded,
//  no done. After release the block is in IDLE.
//  Commands presented while busy are not accepted and are not queued.
// STRUCTURE
//  Shared package uart_link_pkg:
//   - opcode constants OP_SET_HIGH/OP_SET_LOW/OP_SEND_CTRL (8'hA1..A3);
//   - cmd_op encodings;
//   - localparams for default CLK_FREQ/BAUD.
//   The sensor-side command controller imports the same package.
//  Sub-module uart_tx_byte (start/ld/byte_in -> tx, byte_done):
//   - one 8N1 byte serializer with its own baud/bit counters.
//   - the top FSM sequences two loads of it.
// TESTING
//  1 SET_HIGH data 8'h5A, BIT_CYC=10:
//    - tx shows 0,A1 LSB-first,1,0,5A LSB-first,1 at 10-cycle bit spacing;
//    - done occurs 200 cycles after the first start bit.
//  2 SEND_CTRL data 8'hFF:
//    - data byte on the wire is 8'h01;
//    - the UART model decodes bytes A3,01.
//  3 cmd_valid held high with two commands (SET_LOW 8'h10, then SET_HIGH 8'h30):
//    - second accept is 1 cycle after done;
//    - UART decodes A2,10,A1,30; cmd_ready low throughout each frame.
//  4 cmd_op=3:
//    - err pulses 1 cycle after accept; tx stays 1 for 300 cycles;
//    - cmd_ready stays 1; done never pulses.
//  5 rst asserted at cycle 57 of a frame:
//    - tx=1 and busy=0 in the same cycle, no done;
//    - a new SET_LOW 8'h22 after release decodes as A2,22.
//  6 Bench loop to the sensor top:
//    - SET_HIGH 8'h80 then SET_LOW 8'h40 -> sensor temp_high=8'h80, temp_low=8'h40.

Source files
------------

// File: rtl/uart_link_pkg.sv
// uart_link_pkg: opcodes, command encodings and default link rates shared by both ends of the UART link
package uart_link_pkg;

    localparam int DEF_CLK_FREQ = 10000;
    localparam int DEF_BAUD     = 1000;

    localparam logic [7:0] OP_SET_HIGH  = 8'hA1;
    localparam logic [7:0] OP_SET_LOW   = 8'hA2;
    localparam logic [7:0] OP_SEND_CTRL = 8'hA3;

    typedef enum logic [1:0] {
        CMD_SET_HIGH  = 2'd0,
        CMD_SET_LOW   = 2'd1,
        CMD_SEND_CTRL = 2'd2,
        CMD_RSVD      = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP_BYTE,
        ST_DATA_BYTE,
        ST_DONE
    } tx_state_e;

    // Wire opcode for a command; the reserved op never reaches the wire.
    function automatic logic [7:0] op_byte(input logic [1:0] op);
        return op == CMD_SET_HIGH ? OP_SET_HIGH :
               op == CMD_SET_LOW  ? OP_SET_LOW  : OP_SEND_CTRL;
    endfunction

    // Streaming control carries only the enable bit; thresholds go out verbatim.
    function automatic logic [7:0] data_byte(input logic [1:0] op, input logic [7:0] d);
        return op == CMD_SEND_CTRL ? {7'b0, d[0]} : d;
    endfunction

endpackage

// File: rtl/uart_cmd_tx_if.sv
// uart_cmd_tx_if: valid/ready command channel into the UART command transmitter
interface uart_cmd_tx_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);

endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; a load starts a byte immediately, byte_done flags the last stop-bit cycle
module uart_tx_byte #(
    parameter int BIT_CYC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       byte_done
);

    localparam int             CW   = BIT_CYC > 1 ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0]  LAST = CW'(BIT_CYC - 1);

    logic          active;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    sh;
    logic          bit_end;

    assign bit_end   = active && baud_cnt == LAST;
    assign byte_done = bit_end && bit_cnt == 4'd9;

    // A load wins over the end of the previous stop bit so bytes chain with no gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx       <= 1'b1;
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= '1;
        end else if (ld) begin
            tx       <= 1'b0;
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= {1'b1, byte_in};
        end else if (active) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            if (bit_end) begin
                bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
                active  <= !byte_done;
                tx      <= byte_done ? 1'b1 : sh[0];
                sh      <= {1'b1, sh[8:1]};
            end
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: accepts one command per handshake and sends it as an opcode byte plus a data byte
module uart_cmd_tx
    import uart_link_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic          clk,
    input  logic          rst,
    uart_cmd_tx_if.slave  cmd,
    output logic          tx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;

    tx_state_e  state, state_d;
    logic [7:0] data_q;
    logic [7:0] byte_in;
    logic       accept, launch, ld, byte_done;

    assign cmd.cmd_ready = state == ST_IDLE;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign launch        = accept && cmd.cmd_op != CMD_RSVD;
    assign ld            = launch || (state == ST_OP_BYTE && byte_done);
    assign byte_in       = state == ST_IDLE ? op_byte(cmd.cmd_op) : data_q;
    assign busy          = state == ST_OP_BYTE || state == ST_DATA_BYTE;
    assign done          = state == ST_DONE;

    uart_tx_byte #(.BIT_CYC(BIT_CYC)) u_byte (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .byte_in   (byte_in),
        .tx        (tx),
        .byte_done (byte_done)
    );

    // Frame sequencing state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Next state: opcode byte, then data byte, then a one-cycle done.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:      state_d = launch ? ST_OP_BYTE : ST_IDLE;
            ST_OP_BYTE:   state_d = byte_done ? ST_DATA_BYTE : ST_OP_BYTE;
            ST_DATA_BYTE: state_d = byte_done ? ST_DONE : ST_DATA_BYTE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Capture the data byte at accept; flag a rejected reserved op the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            err    <= 1'b0;
        end else begin
            err <= accept && cmd.cmd_op == CMD_RSVD;
            if (accept) data_q <= data_byte(cmd.cmd_op, cmd.cmd_data);
        end
    end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// tb_uart_cmd_tx: table, directed and random checks of uart_cmd_tx against a UART receiver model
module tb_uart_cmd_tx;

    localparam int B = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, busy, done, err;

    uart_cmd_tx_if cif ();

    uart_cmd_tx #(.CLK_FREQ(10000), .BAUD(1000)) dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cif),
        .tx   (tx),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {int t; logic [1:0] op; logic [7:0] d;} acc_t;
    typedef struct {int t; logic [7:0] b; logic stop;} rx_t;
    typedef struct {logic [1:0] op; logic [7:0] d; logic [7:0] e_op; logic [7:0] e_data; bit e_err;} vec_t;

    acc_t acc_q[$];
    rx_t  rx_q[$];
    int   done_q[$];
    int   err_q[$];
    int   ncyc = 0;
    int   ready_viol = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rx_busy = 0;
    int   rx_cnt = 0;
    int   rx_t0 = 0;
    logic [7:0] rx_b = '0;

    // Observer: logs accepts, pulses and decodes tx as an 8N1 receiver sampling mid-bit.
    always @(negedge clk) begin
        ncyc++;
        if (rst) rx_busy = 0;
        else begin
            if (cif.cmd_valid && cif.cmd_ready) acc_q.push_back('{ncyc, cif.cmd_op, cif.cmd_data});
            if (done) done_q.push_back(ncyc);
            if (err) err_q.push_back(ncyc);
            if (busy && cif.cmd_ready) ready_viol++;
            if (!rx_busy) begin
                if (tx === 1'b0) begin
                    rx_busy = 1;
                    rx_cnt  = 0;
                    rx_t0   = ncyc;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % B == B / 2) begin
                    if (rx_cnt / B >= 1 && rx_cnt / B <= 8) rx_b = {tx, rx_b[7:1]};
                    else if (rx_cnt / B == 9) begin
                        rx_q.push_back('{rx_t0, rx_b, tx});
                        rx_busy = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_op(input logic [1:0] op);
        return op == 2'd0 ? 8'hA1 : op == 2'd1 ? 8'hA2 : 8'hA3;
    endfunction

    function automatic logic [7:0] m_data(input logic [1:0] op, input logic [7:0] d);
        return op == 2'd2 ? {7'b0, d[0]} : d;
    endfunction

    task automatic clear_q();
        acc_q.delete();
        rx_q.delete();
        done_q.delete();
        err_q.delete();
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d, input bit hold);
        int n = 0;
        @(posedge clk);
        #2;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = d;
        @(negedge clk);
        while (!cif.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cif.cmd_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #2;
        if (!hold) cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(cif.cmd_ready && !busy && !done) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    // Expected wire traffic and pulse timing derived from the logged accepts.
    task automatic score(input string tag);
        int bi = 0, di = 0, ei = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i].op == 2'd3) begin
                check({tag, "_err_t"}, ei < err_q.size() ? err_q[ei] : -1, acc_q[i].t + 1);
                ei++;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    check({tag, "_byte"}, bi < rx_q.size() ? int'(rx_q[bi].b) : -1,
                          int'(k == 0 ? m_op(acc_q[i].op) : m_data(acc_q[i].op, acc_q[i].d)));
                    check({tag, "_start_t"}, bi < rx_q.size() ? rx_q[bi].t : -1, acc_q[i].t + 1 + k * 10 * B);
                    check({tag, "_stop"}, bi < rx_q.size() ? int'(rx_q[bi].stop) : -1, 1);
                    bi++;
                end
                check({tag, "_done_t"}, di < done_q.size() ? done_q[di] : -1, acc_q[i].t + 1 + 20 * B);
                di++;
            end
        end
        check({tag, "_n_bytes"}, rx_q.size(), bi);
        check({tag, "_n_done"}, done_q.size(), di);
        check({tag, "_n_err"}, err_q.size(), ei);
        clear_q();
    endtask

    initial begin
        vec_t       tbl[6];
        logic [19:0] w;
        int         bad;
        logic [1:0] rop;
        logic [7:0] rd;
        tbl[0] = '{2'd0, 8'h5A, 8'hA1, 8'h5A, 1'b0};
        tbl[1] = '{2'd2, 8'hFF, 8'hA3, 8'h01, 1'b0};
        tbl[2] = '{2'd1, 8'h10, 8'hA2, 8'h10, 1'b0};
        tbl[3] = '{2'd0, 8'h30, 8'hA1, 8'h30, 1'b0};
        tbl[4] = '{2'd3, 8'h77, 8'h00, 8'h00, 1'b1};
        tbl[5] = '{2'd2, 8'hFE, 8'hA3, 8'h00, 1'b0};
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'd0;
        cif.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_ready", int'(cif.cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].op, tbl[i].d, 0);
            wait_idle();
            check("tbl_n_bytes", rx_q.size(), tbl[i].e_err ? 0 : 2);
            if (!tbl[i].e_err && rx_q.size() == 2) begin
                check("tbl_op_byte", int'(rx_q[0].b), int'(tbl[i].e_op));
                check("tbl_data_byte", int'(rx_q[1].b), int'(tbl[i].e_data));
            end
            check("tbl_n_err", err_q.size(), int'(tbl[i].e_err));
            check("tbl_n_done", done_q.size(), int'(!tbl[i].e_err));
            clear_q();
        end
        w = {1'b1, 8'h5A, 1'b0, 1'b1, 8'hA1, 1'b0};
        bad = 0;
        send(2'd0, 8'h5A, 0);
        for (int i = 0; i < 20 * B; i++) begin
            @(negedge clk);
            if (tx !== w[i / B]) bad++;
        end
        check("t1_wave_mismatches", bad, 0);
        wait_idle();
        score("t1");
        send(2'd2, 8'hFF, 0);
        wait_idle();
        check("t2_data", rx_q.size() == 2 ? int'(rx_q[1].b) : -1, 8'h01);
        score("t2");
        ready_viol = 0;
        send(2'd1, 8'h10, 1);
        send(2'd0, 8'h30, 0);
        wait_idle();
        check("t3_n_accept", acc_q.size(), 2);
        check("t3_accept_after_done", acc_q.size() == 2 && done_q.size() > 0 ? acc_q[1].t - done_q[0] : -1, 1);
        check("t3_ready_in_frame", ready_viol, 0);
        score("t3");
        bad = 0;
        send(2'd3, 8'h77, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || cif.cmd_ready !== 1'b1) bad++;
        end
        check("t4_idle_violations", bad, 0);
        score("t4");
        send(2'd1, 8'h55, 0);
        repeat (58) @(negedge clk);
        check("t5_pre_tx", int'(tx), 0);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_tx", int'(tx), 1);
        check("t5_rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        clear_q();
        repeat (250) @(negedge clk);
        check("t5_no_done", done_q.size(), 0);
        check("t5_no_bytes", rx_q.size(), 0);
        send(2'd1, 8'h22, 0);
        wait_idle();
        check("t5_after_op", rx_q.size() == 2 ? int'(rx_q[0].b) : -1, 8'hA2);
        check("t5_after_data", rx_q.size() == 2 ? int'(rx_q[1].b) : -1, 8'h22);
        score("t5");
        ready_viol = 0;
        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            rd  = 8'($urandom);
            send(rop, rd, 0);
            wait_idle();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        score("rand");
        check("rand_ready_in_frame", ready_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
